// File: rtl/dmem_scratchpad.sv
// Data-memory scratchpad: 1-cycle sub-word load/store, sticky fault capture, idle-cycle word loader.
// Optional DMEM_STATS_EN adds saturating load/store counters with a clear input.
module dmem_scratchpad #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned INIT_ZERO   = 0
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           io_req_valid,
   input  logic [31:0]                    io_req_bits_addr,
   input  logic [31:0]                    io_req_bits_data,
   input  logic                           io_req_bits_fcn,
   input  logic [2:0]                     io_req_bits_typ,
   output logic                           io_resp_valid,
   output logic [31:0]                    io_resp_bits_data,
   input  logic                           ld_valid,
   output logic                           ld_ready,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
   input  logic [31:0]                    ld_data,
   output logic                           err_valid,
   output logic [31:0]                    err_addr,
   output logic [1:0]                     err_cause
`ifdef DMEM_STATS_EN
   ,
   input  logic                           stat_clear,
   output logic [31:0]                    stat_loads,
   output logic [31:0]                    stat_stores
`endif
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   typedef enum logic [2:0] {
      TYP_X0 = 3'd0,
      TYP_B  = 3'd1,
      TYP_H  = 3'd2,
      TYP_W  = 3'd3,
      TYP_X4 = 3'd4,
      TYP_BU = 3'd5,
      TYP_HU = 3'd6,
      TYP_X7 = 3'd7
   } typ_e;

   // Contents are never reset; INIT_ZERO only selects the simulation power-up value.
   logic [31:0] r_mem [DEPTH_WORDS] = '{default: ((INIT_ZERO != 0) ? 32'h0 : 32'hxxxx_xxxx)};

   logic [31:0] r_rdata;
   logic        r_vld;
   logic        r_fcn;
   typ_e        r_typ;
   logic [1:0]  r_off;
   logic        r_err;
   logic        r_err_valid;
   logic [31:0] r_err_addr;
   logic [1:0]  r_err_cause;

   typ_e        w_typ;
   logic [AW-1:0] w_idx;
   logic [1:0]  w_off;
   logic        w_mis;
   logic        w_ill;
   logic        w_err;
   logic [1:0]  w_cause;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic        w_acc;
   logic        w_st;
   logic        w_ld;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext;

   assign w_typ = typ_e'(io_req_bits_typ);
   assign w_idx = io_req_bits_addr[AW+1:2];
   assign w_off = io_req_bits_addr[1:0];

   // Write data is replicated across lanes so the byte enable alone picks the target lane.
   always_comb begin
      w_mis   = 1'b0;
      w_ill   = 1'b0;
      w_be    = '0;
      w_wdata = '0;
      case (w_typ)
         TYP_B, TYP_BU: begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{io_req_bits_data[7:0]}};
         end
         TYP_H, TYP_HU: begin
            w_mis   = w_off[0];
            w_be    = w_off[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{io_req_bits_data[15:0]}};
         end
         TYP_W: begin
            w_mis   = (w_off != 2'b00);
            w_be    = '1;
            w_wdata = io_req_bits_data;
         end
         default: w_ill = 1'b1;
      endcase
   end

   assign w_err    = w_mis | w_ill;
   assign w_cause  = w_mis ? 2'd1 : 2'd2;
   assign w_acc    = io_req_valid & ~reset;
   assign w_st     = w_acc & io_req_bits_fcn & ~w_err;
   assign ld_ready = ~io_req_valid & ~reset;
   assign w_ld     = ld_valid & ld_ready;

   always_ff @(posedge clock) begin
      if (w_st) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end else if (w_ld) begin
         r_mem[ld_addr] <= ld_data;
      end
      if (w_acc & ~io_req_bits_fcn) r_rdata <= r_mem[w_idx];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_vld <= 1'b0;
         r_fcn <= 1'b0;
         r_typ <= TYP_X0;
         r_off <= '0;
         r_err <= 1'b0;
      end else begin
         r_vld <= io_req_valid;
         r_fcn <= io_req_bits_fcn;
         r_typ <= w_typ;
         r_off <= w_off;
         r_err <= w_err;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_err_valid <= 1'b0;
         r_err_addr  <= '0;
         r_err_cause <= '0;
      end else if (w_acc & w_err & ~r_err_valid) begin
         r_err_valid <= 1'b1;
         r_err_addr  <= io_req_bits_addr;
         r_err_cause <= w_cause;
      end
   end

   assign w_byte = r_rdata[{r_off, 3'b000} +: 8];
   assign w_half = r_off[1] ? r_rdata[31:16] : r_rdata[15:0];

   always_comb begin
      w_ext = '0;
      case (r_typ)
         TYP_B:   w_ext = {{24{w_byte[7]}}, w_byte};
         TYP_BU:  w_ext = {24'h0, w_byte};
         TYP_H:   w_ext = {{16{w_half[15]}}, w_half};
         TYP_HU:  w_ext = {16'h0, w_half};
         TYP_W:   w_ext = r_rdata;
         default: w_ext = '0;
      endcase
   end

   assign io_resp_valid     = r_vld;
   assign io_resp_bits_data = (r_vld & ~r_fcn & ~r_err) ? w_ext : '0;
   assign err_valid         = r_err_valid;
   assign err_addr          = r_err_addr;
   assign err_cause         = r_err_cause;

`ifdef DMEM_STATS_EN
   logic [31:0] r_loads;
   logic [31:0] r_stores;
   logic        w_cnt;

   assign w_cnt = w_acc & ~w_err;

   always_ff @(posedge clock) begin
      if (reset | stat_clear) begin
         r_loads  <= '0;
         r_stores <= '0;
      end else if (w_cnt) begin
         if (io_req_bits_fcn) begin
            if (r_stores != '1) r_stores <= r_stores + 32'd1;
         end else begin
            if (r_loads != '1) r_loads <= r_loads + 32'd1;
         end
      end
   end

   assign stat_loads  = r_loads;
   assign stat_stores = r_stores;
`endif

endmodule

// File: tb/tb_dmem_scratchpad.sv
// Directed bench for dmem_scratchpad: byte-addressed reference model checked every cycle,
// plus literal expectations on key responses.
module tb_dmem_scratchpad;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned NBYTE = DEPTH * 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_data = '0;
   logic        req_fcn = 1'b0;
   logic [2:0]  req_typ = 3'd3;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [7:0]  ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic        err_valid;
   logic [31:0] err_addr;
   logic [1:0]  err_cause;
`ifdef DMEM_STATS_EN
   logic        stat_clear = 1'b0;
   logic [31:0] stat_loads;
   logic [31:0] stat_stores;
`endif

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   bit          chk_en = 1'b0;

   dmem_scratchpad #(.DEPTH_WORDS(DEPTH), .INIT_ZERO(1)) dut (
      .clock             (clk),
      .reset             (rst),
      .io_req_valid      (req_valid),
      .io_req_bits_addr  (req_addr),
      .io_req_bits_data  (req_data),
      .io_req_bits_fcn   (req_fcn),
      .io_req_bits_typ   (req_typ),
      .io_resp_valid     (resp_valid),
      .io_resp_bits_data (resp_data),
      .ld_valid          (ld_valid),
      .ld_ready          (ld_ready),
      .ld_addr           (ld_addr),
      .ld_data           (ld_data),
      .err_valid         (err_valid),
      .err_addr          (err_addr),
      .err_cause         (err_cause)
`ifdef DMEM_STATS_EN
      ,
      .stat_clear        (stat_clear),
      .stat_loads        (stat_loads),
      .stat_stores       (stat_stores)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // Reference model: byte-addressed memory, behaviour derived from access size and alignment.
   bit [7:0]    mb [NBYTE];
   bit          m_vld = 1'b0;
   bit [31:0]   m_data = '0;
   bit          m_ev = 1'b0;
   bit [31:0]   m_ea = '0;
   bit [1:0]    m_ec = '0;
   bit [31:0]   m_loads = '0;
   bit [31:0]   m_stores = '0;
   int unsigned m_size;
   bit          m_sgn;
   bit          m_legal;
   bit [1:0]    m_fault;
   int unsigned m_ba;
   bit [31:0]   m_val;

   initial foreach (mb[i]) mb[i] = 8'h00;

   always @(posedge clk) begin
      if (rst) begin
         m_vld = 1'b0; m_data = '0;
         m_ev = 1'b0; m_ea = '0; m_ec = '0;
         m_loads = '0; m_stores = '0;
      end else if (req_valid) begin
         m_legal = 1'b1; m_sgn = 1'b0; m_size = 4;
         case (req_typ)
            3'd1: begin m_size = 1; m_sgn = 1'b1; end
            3'd5: m_size = 1;
            3'd2: begin m_size = 2; m_sgn = 1'b1; end
            3'd6: m_size = 2;
            3'd3: m_size = 4;
            default: m_legal = 1'b0;
         endcase
         m_fault = 2'd0;
         if (m_legal && (req_addr % m_size) != 0) m_fault = 2'd1;
         else if (!m_legal) m_fault = 2'd2;
         m_vld = 1'b1;
         m_data = '0;
         if (m_fault != 2'd0) begin
            if (!m_ev) begin m_ev = 1'b1; m_ea = req_addr; m_ec = m_fault; end
         end else begin
            m_ba = req_addr % NBYTE;
            if (req_fcn) begin
               for (int i = 0; i < m_size; i++) mb[m_ba + i] = 8'(req_data >> (8 * i));
               m_stores++;
            end else begin
               m_val = '0;
               for (int i = 0; i < m_size; i++) m_val |= 32'(mb[m_ba + i]) << (8 * i);
               if (m_sgn && m_val[8*m_size-1]) m_val |= 32'hFFFF_FFFF << (8 * m_size);
               m_data = m_val;
               m_loads++;
            end
         end
      end else begin
         m_vld = 1'b0;
         m_data = '0;
         if (ld_valid) for (int i = 0; i < 4; i++) mb[int'(ld_addr) * 4 + i] = 8'(ld_data >> (8 * i));
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("resp_valid", 32'(resp_valid), 32'(m_vld));
         check("resp_data",  resp_data, m_data);
         check("err_valid",  32'(err_valid), 32'(m_ev));
         check("err_addr",   err_addr, m_ea);
         check("err_cause",  32'(err_cause), 32'(m_ec));
         check("ld_ready",   32'(ld_ready), 32'(!req_valid && !rst));
`ifdef DMEM_STATS_EN
         check("stat_loads",  stat_loads, m_loads);
         check("stat_stores", stat_stores, m_stores);
`endif
      end
   end

   task automatic req(input bit v, input bit f, input logic [2:0] t,
                      input logic [31:0] a, input logic [31:0] d);
      req_valid = v; req_fcn = f; req_typ = t; req_addr = a; req_data = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      @(posedge clk); #1;
      chk_en = 1'b1;
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_err_valid",  32'(err_valid), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      req(0, 0, 3'd3, 32'h0, 32'h0);

      req(1, 1, 3'd3, 32'h100, 32'hDEAD_BEEF);
      check("st_w_resp", resp_data, 32'h0);
      req(1, 0, 3'd3, 32'h100, 32'h0);
      check("raw_ld_w", resp_data, 32'hDEAD_BEEF);

      req(1, 1, 3'd1, 32'h203, 32'h1234_5680);
      req(1, 0, 3'd1, 32'h203, 32'h0);
      check("ld_b_sext", resp_data, 32'hFFFF_FF80);
      req(1, 0, 3'd5, 32'h203, 32'h0);
      check("ld_bu", resp_data, 32'h0000_0080);
      req(1, 0, 3'd3, 32'h200, 32'h0);
      check("ld_w_after_b", resp_data, 32'h8000_0000);

      req(1, 1, 3'd2, 32'h302, 32'hABCD_8001);
      req(1, 0, 3'd2, 32'h302, 32'h0);
      check("ld_h_sext", resp_data, 32'hFFFF_8001);
      req(1, 0, 3'd6, 32'h302, 32'h0);
      check("ld_hu", resp_data, 32'h0000_8001);

      req(1, 1, 3'd5, 32'h101, 32'h0000_0011);
      req(1, 0, 3'd3, 32'h100, 32'h0);
      check("ld_w_merge", resp_data, 32'hDEAD_11EF);
      req(1, 0, 3'd2, 32'h102, 32'h0);
      check("ld_h_upper", resp_data, 32'hFFFF_DEAD);
      req(1, 0, 3'd3, 32'h500, 32'h0);
      check("alias_ld_w", resp_data, 32'hDEAD_11EF);

      ld_valid = 1'b1; ld_addr = 8'd5; ld_data = 32'h1234_5678;
      req(1, 0, 3'd3, 32'h200, 32'h0);
      req(1, 0, 3'd1, 32'h100, 32'h0);
      req(1, 1, 3'd3, 32'h40, 32'h0000_00AA);
      req(0, 0, 3'd3, 32'h0, 32'h0);
      ld_valid = 1'b0;
      req(1, 0, 3'd3, 32'h14, 32'h0);
      check("loader_ld_w", resp_data, 32'h1234_5678);

      req(1, 0, 3'd3, 32'h101, 32'h0);
      check("mis_resp_valid", 32'(resp_valid), 32'h1);
      check("mis_resp_data", resp_data, 32'h0);
      check("mis_err_addr", err_addr, 32'h101);
      check("mis_err_cause", 32'(err_cause), 32'h1);
      req(1, 1, 3'd4, 32'h104, 32'h0000_0099);
      check("sticky_addr", err_addr, 32'h101);
      check("sticky_cause", 32'(err_cause), 32'h1);
      req(1, 1, 3'd2, 32'h303, 32'h0000_FFFF);
      req(1, 0, 3'd3, 32'h300, 32'h0);
      check("mis_st_nowrite", resp_data, 32'h8001_0000);
      req(1, 0, 3'd3, 32'h104, 32'h0);
      check("ill_st_nowrite", resp_data, 32'h0);

      req(1, 0, 3'd3, 32'h300, 32'h0);
      rst = 1'b1;
      ld_valid = 1'b1; ld_addr = 8'd6; ld_data = 32'h0000_0055;
      req(1, 1, 3'd3, 32'h14, 32'hCAFE_F00D);
      check("rst_drop_resp", 32'(resp_valid), 32'h0);
      check("rst_clr_err", 32'(err_valid), 32'h0);
`ifdef DMEM_STATS_EN
      check("rst_stat_loads", stat_loads, 32'h0);
      check("rst_stat_stores", stat_stores, 32'h0);
`endif
      rst = 1'b0;
      ld_valid = 1'b0;
      req(1, 0, 3'd3, 32'h14, 32'h0);
      check("rst_st_dropped", resp_data, 32'h1234_5678);
      req(1, 0, 3'd3, 32'h18, 32'h0);
      check("rst_ld_dropped", resp_data, 32'h0);
      req(1, 0, 3'd7, 32'h20, 32'h0);
      check("ill_err_addr", err_addr, 32'h20);
      check("ill_err_cause", 32'(err_cause), 32'h2);
      req(0, 0, 3'd3, 32'h0, 32'h0);
      req(0, 0, 3'd3, 32'h0, 32'h0);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_scratchpad.md
Name: dmem_scratchpad

Overview:
- Data-memory scratchpad directly downstream of the core's data-memory request port.
- Consumes io_dmem_req_* (valid/addr/data/fcn/typ) and returns io_dmem_resp_valid/io_dmem_resp_bits_data one cycle later.
- Handles byte/half/word sub-word access, sign or zero extension, and misalignment detection.
- Provides a low-priority word loader port for preloading program data.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words (power of 2); word index = addr[log2(DEPTH_WORDS)+1:2], upper address bits ignored (aliasing).
- INIT_ZERO, 0, 1 = array cleared by initial block (simulation only; no reset clearing).

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- io_req_valid  in  1  core request valid (no ready; must be accepted every cycle)
- io_req_bits_addr  in  32  byte address
- io_req_bits_data  in  32  store data, right-aligned
- io_req_bits_fcn  in  1  0 = load, 1 = store
- io_req_bits_typ  in  3  1=B, 2=H, 3=W, 5=BU, 6=HU; 0/4/7 illegal
- io_resp_valid  out  1  response valid
- io_resp_bits_data  out  32  load result (extended); 0 for stores and errors
- ld_valid  in  1  loader write request
- ld_ready  out  1  loader accepted
- ld_addr  in  log2(DEPTH_WORDS)  word index
- ld_data  in  32  full-word write data
- err_valid  out  1  sticky error flag
- err_addr  out  32  address of first faulting request
- err_cause  out  2  1 = misaligned, 2 = illegal typ

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset values: io_resp_valid=0, io_resp_bits_data=0, err_valid=0, err_addr=0, err_cause=0. Memory array is not reset.
- Reset mid-operation: a request presented in the reset cycle is dropped (no write, no response next cycle). A loader write in the reset cycle is also dropped, and ld_ready=0 during reset.
- Stage 0 (request cycle N): decode typ and addr[1:0]; build 4-bit byte enable and lane-shifted write data.
  - B/BU: enable 1<<addr[1:0].
  - H/HU: enable 0011 or 1100 by addr[1].
  - W: enable 1111.
- Stores: byte-enabled array write at the end of cycle N.
- Loads: synchronous array read registered at the end of cycle N. Pipeline registers capture valid, fcn, typ, addr[1:0] and error.
- Stage 1 (cycle N+1): io_resp_valid=1 for every accepted request (load or store).
  - Loads: extract the addressed lane, shift to bit 0; sign-extend for B/H, zero-extend for BU/HU; W passes unchanged.
- Latency: fixed 1 cycle; back-to-back requests are fully pipelined, one response per cycle.
- Read-after-write: a store in N followed by a load of the same word in N+1 returns the updated data (no bypass needed, since the write commits before the read).
- Same-cycle read and write to one word cannot occur (single request per cycle).
- Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0):
  - no write; response still issued with data 0;
  - if err_valid=0: set err_valid, capture err_addr and err_cause=1.
- Illegal typ: same handling, err_cause=2.
- Misalignment is checked before typ legality; only the first error is held (sticky) until reset.
- Loader arbitration: ld_ready = ~io_req_valid & ~reset. Core always wins. On ld_valid&ld_ready, write ld_data with all byte enables at ld_addr. No response is generated for loader writes.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined: adds outputs stat_loads[31:0] and stat_stores[31:0], plus stat_clear (input, 1 bit).
  - Counters increment on each accepted, non-faulting core load/store in stage 0.
  - Counters saturate at 32'hFFFF_FFFF.
  - Reset to 0 on reset or stat_clear; clear wins over a same-cycle increment.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Store W 0xDEADBEEF @0x100, then load W @0x100 next cycle -> resp_valid each cycle, load data 0xDEADBEEF, store resp data 0.
- Store B 0x80 @0x203; load B @0x203 -> 0xFFFFFF80; load BU @0x203 -> 0x00000080; load W @0x200 -> 0x80xxxxxx with the other bytes unchanged.
- Store H 0x8001 @0x302; load H -> 0xFFFF8001; load HU -> 0x00008001.
- Load W @0x101 -> resp_valid=1, data 0, err_valid=1, err_addr=0x101, err_cause=1. A later typ=4 access leaves err_addr/err_cause unchanged.
- Loader: hold ld_valid with ld_addr=5, ld_data=0x12345678 while core requests run for 3 cycles -> ld_ready=0 for those cycles; write occurs on the first idle cycle; core load W @0x14 -> 0x12345678.
- Assert reset with a store in flight -> no resp next cycle, target word unchanged; with DMEM_STATS_EN, counters read 0 after reset.
